// File: rtl/ntru_ternary_convolver.sv
// rtl/ntru_ternary_convolver.sv - serial Horner multiplier h*r in Z_(2^QBITS)[x]/(x^N - 1), r ternary and streamed
// Optional macro NTRU_CONV_NEGACYCLIC_EN adds a negacyclic input selecting the ring x^N + 1.
module ntru_ternary_convolver #(
    parameter int N     = 701,
    parameter int QBITS = 13,
    parameter int CW    = $clog2(N)
) (
    input  logic               lcl_clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N*QBITS-1:0] h,
    input  logic [1:0]         r_coef,
    input  logic               r_valid,
`ifdef NTRU_CONV_NEGACYCLIC_EN
    input  logic               negacyclic,
`endif
    output logic               r_ready,
    output logic               busy,
    output logic               done,
    output logic               e_valid,
    output logic [N*QBITS-1:0] e,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [N*QBITS-1:0] h_reg;
    logic [N*QBITS-1:0] acc;
    logic [N*QBITS-1:0] acc_next;
    logic [CW-1:0]      count;
    logic               accept;
    logic               last;
    logic [QBITS-1:0]   hc, th, prev;
`ifdef NTRU_CONV_NEGACYCLIC_EN
    logic               neg_reg;
`endif

    assign accept = r_valid & r_ready;
    assign last   = (count == CW'(N - 1));
    assign e      = acc;

    always_ff @(posedge lcl_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        r_ready    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy    = 1'b1;
                r_ready = 1'b1;
                if (accept && last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One Horner step: rotate the accumulator up by one and add t(h) lane-wise.
    always_comb begin
        acc_next = acc;
        hc       = '0;
        th       = '0;
        prev     = '0;
        for (int i = 0; i < N; i++) begin
            hc = h_reg[i*QBITS +: QBITS];
            case (r_coef)
                2'b01:   th = hc;
                2'b11:   th = QBITS'(0) - hc;
                default: th = '0;
            endcase
            prev = acc[((i + N - 1) % N)*QBITS +: QBITS];
`ifdef NTRU_CONV_NEGACYCLIC_EN
            if (neg_reg && i == 0) prev = QBITS'(0) - prev;
`endif
            acc_next[i*QBITS +: QBITS] = prev + th;
        end
    end

    always_ff @(posedge lcl_clk) begin
        if (rst) begin
            h_reg   <= '0;
            acc     <= '0;
            count   <= '0;
            err     <= 1'b0;
            e_valid <= 1'b0;
`ifdef NTRU_CONV_NEGACYCLIC_EN
            neg_reg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    h_reg   <= h;
                    acc     <= '0;
                    count   <= '0;
                    err     <= 1'b0;
                    e_valid <= 1'b0;
`ifdef NTRU_CONV_NEGACYCLIC_EN
                    neg_reg <= negacyclic;
`endif
                end
                RUN: if (accept) begin
                    acc <= acc_next;
                    if (r_coef == 2'b10) err <= 1'b1;
                    if (last) count <= '0;
                    else      count <= count + 1'b1;
                end
                DONE: e_valid <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ntru_ternary_convolver.sv
// tb/tb_ntru_ternary_convolver.sv - scoreboard bench for ntru_ternary_convolver at N=4, QBITS=13
module tb_ntru_ternary_convolver;

    localparam int N = 4;
    localparam int QBITS = 13;
    localparam int W = N * QBITS;

    logic         lcl_clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] h_in;
    logic [1:0]   r_coef;
    logic         r_valid;
    logic         r_ready, busy, done, e_valid, err;
    logic [W-1:0] e;
`ifdef NTRU_CONV_NEGACYCLIC_EN
    logic         negacyclic;
`endif

    int compared = 0;
    int mismatched = 0;
    int done_count = 0;
    bit pending_ev = 1'b0;

    logic [W-1:0] exp_e_q[$];
    logic         exp_err_q[$];
    string        name_q[$];

    ntru_ternary_convolver #(.N(N), .QBITS(QBITS)) dut (
        .lcl_clk(lcl_clk),
        .rst(rst),
        .start(start),
        .h(h_in),
        .r_coef(r_coef),
        .r_valid(r_valid),
`ifdef NTRU_CONV_NEGACYCLIC_EN
        .negacyclic(negacyclic),
`endif
        .r_ready(r_ready),
        .busy(busy),
        .done(done),
        .e_valid(e_valid),
        .e(e),
        .err(err)
    );

    always #5 lcl_clk = ~lcl_clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input int a0, input int a1, input int a2, input int a3);
        return {QBITS'(a3), QBITS'(a2), QBITS'(a1), QBITS'(a0)};
    endfunction

    // Monitor: every done pulse pops one expected result; e_valid must follow a cycle later.
    always @(negedge lcl_clk) begin
        if (pending_ev) begin
            check({"e_valid_after_", name_q[0]}, 64'(e_valid), 64'd1);
            void'(name_q.pop_front());
            pending_ev = 1'b0;
        end
        if (!rst && done) begin
            done_count++;
            if (exp_e_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                check({name_q[0], "_e"}, 64'(e), 64'(exp_e_q.pop_front()));
                check({name_q[0], "_err"}, 64'(err), 64'(exp_err_q.pop_front()));
                pending_ev = 1'b1;
            end
        end
    end

    task automatic send(input logic [1:0] c);
        int t;
        r_coef  = c;
        r_valid = 1'b1;
        t = 0;
        while (!r_ready && t < 50) begin
            @(negedge lcl_clk);
            t++;
        end
        if (t >= 50) check("r_ready_timeout", 64'd0, 64'd1);
        @(posedge lcl_clk);
        @(negedge lcl_clk);
        r_valid = 1'b0;
        r_coef  = 2'b00;
    endtask

    task automatic pulse_start(input logic [W-1:0] hv, input bit neg);
        h_in  = hv;
        start = 1'b1;
`ifdef NTRU_CONV_NEGACYCLIC_EN
        negacyclic = neg;
`else
        if (neg) check("negacyclic_unsupported", 64'd1, 64'd0);
`endif
        @(negedge lcl_clk);
        start = 1'b0;
        h_in  = ~hv;
`ifdef NTRU_CONV_NEGACYCLIC_EN
        negacyclic = ~neg;
`endif
    endtask

    // codes[7:6] is r3 (streamed first) ... codes[1:0] is r0.
    task automatic run_op(input string nm, input logic [W-1:0] hv, input logic [7:0] codes,
                          input int gap, input bit poke, input bit neg,
                          input logic [W-1:0] exp_e, input logic exp_err);
        exp_e_q.push_back(exp_e);
        exp_err_q.push_back(exp_err);
        name_q.push_back(nm);
        pulse_start(hv, neg);
        for (int k = 0; k < N; k++) begin
            send(codes[(N-1-k)*2 +: 2]);
            if (k < N - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (poke && g == 1) begin
                        start = 1'b1;
                        h_in  = pack(7, 7, 7, 7);
                    end
                    @(negedge lcl_clk);
                    start = 1'b0;
                end
            end
        end
        check({nm, "_done_latency"}, 64'(done), 64'd1);
        check({nm, "_r_ready_after_last"}, 64'(r_ready), 64'd0);
        repeat (3) @(negedge lcl_clk);
    endtask

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; h_in = '0; r_coef = 2'b00; r_valid = 1'b0;
`ifdef NTRU_CONV_NEGACYCLIC_EN
        negacyclic = 1'b0;
`endif
        repeat (2) @(negedge lcl_clk);
        rst = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_e_valid", 64'(e_valid), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_r_ready", 64'(r_ready), 64'd0);
        check("reset_e", 64'(e), 64'd0);

        run_op("t1_identity", pack(1, 2, 3, 4), 8'b00_00_00_01, 0, 1'b0, 1'b0, pack(1, 2, 3, 4), 1'b0);
        run_op("t2_times_x", pack(1, 2, 3, 4), 8'b00_00_01_00, 0, 1'b0, 1'b0, pack(4, 1, 2, 3), 1'b0);
`ifdef NTRU_CONV_NEGACYCLIC_EN
        run_op("t2_negacyclic", pack(1, 2, 3, 4), 8'b00_00_01_00, 0, 1'b0, 1'b1, pack(8188, 1, 2, 3), 1'b0);
`endif
        run_op("t3_minus_one", pack(1, 2, 3, 4), 8'b00_00_00_11, 0, 1'b0, 1'b0,
               pack(8191, 8190, 8189, 8188), 1'b0);
        run_op("t4_wrap", pack(8191, 8191, 8191, 8191), 8'b01_01_00_00, 0, 1'b0, 1'b0,
               pack(8190, 8190, 8190, 8190), 1'b0);

        dc = done_count;
        run_op("t5_gaps_poke", pack(1, 2, 3, 4), 8'b00_00_00_01, 3, 1'b1, 1'b0, pack(1, 2, 3, 4), 1'b0);
        check("t5_single_done", 64'(done_count - dc), 64'd1);
        check("t5_idle_after", 64'(busy), 64'd0);

        pulse_start(pack(1, 2, 3, 4), 1'b0);
        send(2'b01);
        send(2'b01);
        rst = 1'b1;
        @(negedge lcl_clk);
        rst = 1'b0;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_e_valid", 64'(e_valid), 64'd0);
        check("t6_rst_e", 64'(e), 64'd0);
        repeat (2) @(negedge lcl_clk);
        run_op("t6_illegal", pack(1, 2, 3, 4), 8'b10_00_00_01, 0, 1'b0, 1'b0, pack(1, 2, 3, 4), 1'b1);

        check("scoreboard_drained", 64'(exp_e_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
